// File: rtl/banco_registradores_param.sv
// banco_registradores_param: parametrised register bank with NUM_RD registered read ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge write data to matching read ports.
module banco_registradores_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [NUM_RD-1:0]          rdEn,
  input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
  output logic [NUM_RD*DATA_W-1:0]   rdData,
  output logic [NUM_RD-1:0]          rdReady,
  input  logic                       wrEn,
  input  logic [ADDR_W-1:0]          wrAddr,
  input  logic [DATA_W-1:0]          wrData,
  input  logic                       rsvEn,
  input  logic [ADDR_W-1:0]          rsvAddr,
  output logic                       rsvStall,
  output logic [2**ADDR_W-1:0]       busy
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_nxt;
  logic [DATA_W-1:0] rd_val [NUM_RD];
  logic [NUM_RD-1:0] rd_rdy;
  logic              wr_ok, rsv_ok, rsv_zero;
  assign wr_ok    = enable && wrEn && !(ZERO_REG != 0 && wrAddr == '0);
  assign rsv_zero = ZERO_REG != 0 && rsvAddr == '0;
  // a write landing on the same edge releases the register, so the reservation can go through
  assign rsvStall = enable && rsvEn && !rsv_zero && busy[rsvAddr] && !(wrEn && wrAddr == rsvAddr);
  assign rsv_ok   = enable && rsvEn && !rsv_zero && !rsvStall;
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) busy_nxt[wrAddr] = 1'b0;
    if (rsv_ok) busy_nxt[rsvAddr] = 1'b1;
  end
  genvar i;
  for (i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              rz, byp;
    assign ra = rdAddr[i*ADDR_W +: ADDR_W];
    assign rz = ZERO_REG != 0 && ra == '0;
`ifdef REGFILE_BYPASS_EN
    assign byp = wr_ok && wrAddr == ra;
`else
    assign byp = 1'b0;
`endif
    assign rd_val[i] = rz ? '0 : byp ? wrData : mem[ra];
    assign rd_rdy[i] = rz || byp || !busy[ra];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
      busy    <= '0;
      rdData  <= '0;
      rdReady <= '0;
    end else if (enable) begin
      if (wr_ok) mem[wrAddr] <= wrData;
      busy <= busy_nxt;
      for (int k = 0; k < NUM_RD; k++)
        if (rdEn[k]) begin
          rdData[k*DATA_W +: DATA_W] <= rd_val[k];
          rdReady[k]                 <= rd_rdy[k];
        end
    end
  end
endmodule

// File: tb/tb_banco_registradores_param.sv
// tb_banco_registradores_param: directed vectors with a read scoreboard for banco_registradores_param.
module tb_banco_registradores_param;
  logic        clock = 1'b0;
  logic        reset_n, enable;
  logic [1:0]  rdEn;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;
  logic [1:0]  rdReady;
  logic        wrEn, rsvEn, rsvStall;
  logic [4:0]  wrAddr, rsvAddr;
  logic [31:0] wrData;
  logic [31:0] busy;

  banco_registradores_param dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData), .rdReady(rdReady),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .rsvEn(rsvEn), .rsvAddr(rsvAddr), .rsvStall(rsvStall), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
    string       nm;
  } exp_t;
  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic rd_fire;

  always @(posedge clock or negedge reset_n)
    if (!reset_n) rd_fire <= 1'b0;
    else rd_fire <= enable && |rdEn;

  always @(negedge clock) begin
    exp_t e;
    if (rd_fire) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: rdData=%h with no expectation queued", rdData);
      end else begin
        e = q.pop_front();
        if (rdData !== e.d) begin
          n_fail++;
          $display("FAIL %s data: got %h expected %h", e.nm, rdData, e.d);
        end
        n_chk++;
        if (rdReady !== e.r) begin
          n_fail++;
          $display("FAIL %s ready: got %b expected %b", e.nm, rdReady, e.r);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic clr();
    rdEn = '0; wrEn = 0; rsvEn = 0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [31:0] e0,
                    input logic [31:0] e1, input logic [1:0] r, input string nm);
    rdEn = 2'b11; rdAddr = {a1, a0};
    q.push_back('{{e1, e0}, r, nm});
    cyc(); clr();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wrEn = 1; wrAddr = a; wrData = d;
    cyc(); clr();
  endtask

  task automatic rsv(input logic [4:0] a);
    rsvEn = 1; rsvAddr = a;
    #1 chk("rsv_stall_free", 64'(rsvStall), 64'd0);
    cyc(); clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; enable = 1; rdAddr = '0; wrAddr = '0; wrData = '0; rsvAddr = '0;
    clr();
    cyc(); cyc();
    reset_n = 1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rdData", rdData, 64'd0);
    chk("reset_rdReady", 64'(rdReady), 64'd0);
    // 1: write + reserve, then async reset mid-cycle wipes both
    wrEn = 1; wrAddr = 5; wrData = 32'hDEADBEEF; rsvEn = 1; rsvAddr = 4;
    cyc(); clr();
    chk("pre_reset_busy4", 64'(busy[4]), 64'd1);
    #1 reset_n = 0;
    #1 chk("async_reset_busy", 64'(busy), 64'd0);
    reset_n = 1;
    rd(5, 5, 32'h0, 32'h0, 2'b11, "after_reset_r5");
    // 2: write then read on both ports
    wr(3, 32'h12345678);
    rd(3, 3, 32'h12345678, 32'h12345678, 2'b11, "r3_both");
    // 3: zero register ignores write and reserve
    wrEn = 1; wrAddr = 0; wrData = 32'hFFFFFFFF; rsvEn = 1; rsvAddr = 0;
    #1 chk("r0_stall", 64'(rsvStall), 64'd0);
    cyc(); clr();
    chk("r0_busy", 64'(busy[0]), 64'd0);
    rd(0, 0, 32'h0, 32'h0, 2'b11, "r0_read");
    // 4: reserve / stall / release handshake
    rsv(7);
    chk("r7_busy_set", 64'(busy[7]), 64'd1);
    rd(7, 3, 32'h0, 32'h12345678, 2'b10, "r7_pending");
    rsvEn = 1; rsvAddr = 7;
    #1 chk("r7_rsv_stall", 64'(rsvStall), 64'd1);
    cyc(); clr();
    chk("r7_still_busy", 64'(busy[7]), 64'd1);
    wr(7, 32'h55);
    chk("r7_released", 64'(busy[7]), 64'd0);
    rd(7, 7, 32'h55, 32'h55, 2'b11, "r7_done");
    // simultaneous write + reserve to a busy register: no stall, reserve wins
    rsv(8);
    wrEn = 1; wrAddr = 8; wrData = 32'h77; rsvEn = 1; rsvAddr = 8;
    #1 chk("r8_wr_rsv_stall", 64'(rsvStall), 64'd0);
    cyc(); clr();
    chk("r8_busy_after", 64'(busy[8]), 64'd1);
    rd(8, 0, 32'h77, 32'h0, 2'b10, "r8_read");
    // 5: same-cycle write and read of a pending register
    wr(9, 32'h11);
    rsv(9);
    wrEn = 1; wrAddr = 9; wrData = 32'hA5;
`ifdef REGFILE_BYPASS_EN
    rd(9, 9, 32'hA5, 32'hA5, 2'b11, "r9_bypass");
`else
    rd(9, 9, 32'h11, 32'h11, 2'b00, "r9_no_bypass");
`endif
    rd(9, 9, 32'hA5, 32'hA5, 2'b11, "r9_after");
    // 6: enable low freezes everything
    enable = 0; wrEn = 1; wrAddr = 9; wrData = 32'hBAD; rsvEn = 1; rsvAddr = 8;
    rdEn = 2'b11; rdAddr = {5'd3, 5'd3};
    #1 chk("disabled_stall", 64'(rsvStall), 64'd0);
    cyc(); clr();
    chk("disabled_rdData", rdData, {32'hA5, 32'hA5});
    chk("disabled_rdReady", 64'(rdReady), 64'd3);
    chk("disabled_busy", 64'(busy), 64'h100);
    enable = 1;
    rd(9, 10, 32'hA5, 32'h0, 2'b11, "post_disable");
    cyc(); cyc();
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
